// File: rtl/mem_bist.sv
// Self-checking RAM test master: writes an address-derived pattern, reads it back and reports errors.
// Optional inverted-pattern second pass is enabled by defining MEM_BIST_INV_PASS_EN.
module mem_bist #(
    parameter int LEN = 256,
    parameter int DW  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [$clog2(LEN)-1:0]    addr,
    output logic [DW-1:0]             d,
    output logic                      wr,
    input  logic [DW-1:0]             q,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [$clog2(LEN)+1:0]    err_cnt,
    output logic [$clog2(LEN)-1:0]    fail_addr
);
    localparam int AW = $clog2(LEN);
    localparam int CW = $clog2(LEN) + 2;
    localparam logic [AW-1:0] LAST = AW'(LEN - 1);

`ifdef MEM_BIST_INV_PASS_EN
    typedef enum logic [2:0] {IDLE, W0, R0, D0, W1, R1, D1, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, W0, R0, D0, DONE} state_t;
`endif

    state_t        state;
    logic          rd_vld;
    logic [DW-1:0] exp;
    logic [AW-1:0] rd_addr;
    logic          mism;
    logic [CW-1:0] err_nxt;

    function automatic logic [DW-1:0] pat0(input logic [AW-1:0] a);
        return DW'(a);
    endfunction

    function automatic logic [DW-1:0] pat1(input logic [AW-1:0] a);
        return ~DW'(a);
    endfunction

    // Compare the read issued last cycle against its registered expectation.
    always_comb begin
        mism    = rd_vld && (q != exp);
        err_nxt = mism ? err_cnt + CW'(1) : err_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            d         <= '0;
            wr        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            rd_vld    <= 1'b0;
            exp       <= '0;
            rd_addr   <= '0;
        end else begin
            rd_vld <= 1'b0;
            if (mism) begin
                err_cnt <= err_nxt;
                if (err_cnt == '0) fail_addr <= rd_addr;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= W0;
                        addr      <= '0;
                        wr        <= 1'b1;
                        d         <= pat0('0);
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_cnt   <= '0;
                        fail_addr <= '0;
                    end
                end
                W0: begin
                    if (addr == LAST) begin
                        state <= R0;
                        addr  <= '0;
                        wr    <= 1'b0;
                        d     <= '0;
                    end else begin
                        addr <= addr + AW'(1);
                        d    <= pat0(addr + AW'(1));
                    end
                end
                R0: begin
                    rd_vld  <= 1'b1;
                    exp     <= pat0(addr);
                    rd_addr <= addr;
                    if (addr == LAST) begin
                        state <= D0;
                        addr  <= '0;
                    end else begin
                        addr <= addr + AW'(1);
                    end
                end
`ifdef MEM_BIST_INV_PASS_EN
                D0: begin
                    state <= W1;
                    addr  <= '0;
                    wr    <= 1'b1;
                    d     <= pat1('0);
                end
                W1: begin
                    if (addr == LAST) begin
                        state <= R1;
                        addr  <= '0;
                        wr    <= 1'b0;
                        d     <= '0;
                    end else begin
                        addr <= addr + AW'(1);
                        d    <= pat1(addr + AW'(1));
                    end
                end
                R1: begin
                    rd_vld  <= 1'b1;
                    exp     <= pat1(addr);
                    rd_addr <= addr;
                    if (addr == LAST) begin
                        state <= D1;
                        addr  <= '0;
                    end else begin
                        addr <= addr + AW'(1);
                    end
                end
                D1: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_nxt == '0);
                end
`else
                // Drain cycle: the final read's compare lands on this edge, so pass uses err_nxt.
                D0: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_nxt == '0);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: RAM model with injectable faults, arithmetic reference of expected results.
module tb_mem_bist;
    localparam int LEN = 16;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int CW  = 6;
`ifdef MEM_BIST_INV_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic          wr;
    logic [DW-1:0] q;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] err_cnt;
    logic [AW-1:0] fail_addr;

    int n_cmp = 0;
    int n_mis = 0;

    // Memory fault injection: one address with stuck-at-0/1 masks, or whole read bus forced to 0xFF.
    int          fault_addr = -1;
    logic [7:0]  sa0_mask = 8'h00;
    logic [7:0]  sa1_mask = 8'h00;
    bit          force_ff = 1'b0;
    logic [7:0]  mem [LEN];
    logic [7:0]  q_reg = 8'h00;

    mem_bist #(.LEN(LEN), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .d(d), .wr(wr), .q(q),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr) mem[addr] <= (int'(addr) == fault_addr) ? ((d & ~sa0_mask) | sa1_mask) : d;
        q_reg <= mem[addr];
    end
    assign q = force_ff ? 8'hFF : q_reg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_mis++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    // Expected result of a full run, from the pattern definitions alone.
    function automatic void model(output int cnt, output int faddr);
        logic [7:0] wv, stored, rd;
        cnt = 0;
        faddr = 0;
        for (int p = 0; p < NPASS; p++) begin
            for (int a = 0; a < LEN; a++) begin
                wv = (p == 0) ? 8'(a) : ~8'(a);
                stored = (a == fault_addr) ? ((wv & ~sa0_mask) | sa1_mask) : wv;
                rd = force_ff ? 8'hFF : stored;
                if (rd != wv) begin
                    if (cnt == 0) faddr = a;
                    cnt++;
                end
            end
        end
    endfunction

    task automatic run(input string tag, input int restart_at);
        int cyc, wr_hi, e_cnt, e_fa;
        model(e_cnt, e_fa);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_start_busy"}, 32'(busy), 1);
        chk({tag, "_start_done"}, 32'(done), 0);
        chk({tag, "_start_err"}, 32'(err_cnt), 0);
        chk({tag, "_start_fa"}, 32'(fail_addr), 0);
        wr_hi = int'(wr);
        cyc = 0;
        while (!done && cyc < 500) begin
            start = (cyc == restart_at);
            @(posedge clk); #1;
            cyc++;
            if (wr) wr_hi++;
        end
        start = 1'b0;
        chk({tag, "_len"}, 32'(cyc), 32'(NPASS * (2 * LEN + 1)));
        chk({tag, "_wr_cycles"}, 32'(wr_hi), 32'(NPASS * LEN));
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_err"}, 32'(err_cnt), 32'(e_cnt));
        chk({tag, "_fa"}, 32'(fail_addr), 32'(e_fa));
        chk({tag, "_pass"}, 32'(pass), 32'(e_cnt == 0));
        repeat (2) @(posedge clk);
        #1 chk({tag, "_hold"}, 32'({done, pass, wr, busy}), 32'({1'b1, e_cnt == 0, 1'b0, 1'b0}));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 32'(addr), 0);
        chk({tag, "_d"}, 32'(d), 0);
        chk({tag, "_ctl"}, 32'({wr, busy, done, pass}), 0);
        chk({tag, "_err"}, 32'(err_cnt), 0);
        chk({tag, "_fa"}, 32'(fail_addr), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        run("clean", -1);

        fault_addr = 4; sa1_mask = 8'h01;
        run("stuck1_a4", -1);

        fault_addr = -1; sa1_mask = 8'h00;
        run("repaired", -1);

        force_ff = 1'b1;
        run("q_ff", -1);
        force_ff = 1'b0;

        run("restart_ignored", 5);

        for (int i = 0; i < 6; i++) begin
            fault_addr = int'($urandom_range(LEN - 1, 0));
            if ($urandom_range(1, 0) == 1) begin
                sa1_mask = 8'(1) << $urandom_range(7, 0);
                sa0_mask = 8'h00;
            end else begin
                sa0_mask = 8'(1) << $urandom_range(7, 0);
                sa1_mask = 8'h00;
            end
            run($sformatf("rand%0d", i), -1);
        end
        fault_addr = -1; sa0_mask = 8'h00; sa1_mask = 8'h00;

        fault_addr = 7; sa0_mask = 8'h02;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("midrun_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk) rst = 1'b0;
        fault_addr = -1; sa0_mask = 8'h00;
        @(negedge clk);
        run("after_rst", -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/mem_bist.md
Name: mem_bist

Overview:
- Self-checking memory test master. Drives a `membus`-style slave port (addr/d/wr out, q in) directly upstream of the single-port RAM with one-cycle registered read.
- Writes an address-derived pattern to every location, reads each location back, compares the data and reports pass/fail, error count and first failing address.
- Replaces the free-running write-only tester for power-on and regression checks.

Parameters:
- LEN, 256, number of memory words; addressed 0..LEN-1.
- DW, 8, data width.
- AW, $clog2(LEN), address width (localparam).
- CW, $clog2(LEN)+2, error counter width (localparam); holds up to 2*LEN with no saturation.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- addr  output  AW  memory address (registered).
- d  output  DW  write data (registered); 0 outside write phases.
- wr  output  1  write enable (registered).
- q  input  DW  read data; valid one cycle after addr is presented with wr=0.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high in DONE; held until restart or reset.
- pass  output  1  valid while done; equals (err_cnt==0).
- err_cnt  output  CW  number of mismatches in the current run.
- fail_addr  output  AW  address of the first mismatch in the run; 0 if none.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. addr, d, wr, busy, done, pass, err_cnt, fail_addr and all internal compare pipeline regs go to 0.
- States: IDLE, W0, R0, D0, (W1, R1, D1 with feature), DONE.
- IDLE or DONE with start=1 at an edge: next state W0, addr=0, wr=1, d=pat0(0). At the same edge err_cnt, fail_addr, done and pass clear.
- start is ignored in every other state.
- Patterns: pat0(a)=DW'(a) (zero-extend or truncate); pat1(a)=~DW'(a).
- W0:
  - One write per cycle, addr 0..LEN-1, wr=1, d=pat0(addr).
  - After the write to LEN-1: go to R0 with addr=0, wr=0, d=0.
- R0:
  - One read per cycle, addr 0..LEN-1.
  - Each cycle registers rd_vld=1, exp=pat0(addr) and rd_addr=addr.
  - After the read of LEN-1: go to D0.
- D0: one drain cycle with wr=0 and no new read, so the last read's compare completes.
- Compare (every cycle): if rd_vld and q!=exp, then err_cnt+=1. If this is the first mismatch of the run, fail_addr=rd_addr.
- D0 exit: to W1 (feature on) or DONE (feature off).
- W1/R1/D1: identical to W0/R0/D0 but using pat1.
- DONE: busy=0, done=1, pass=(err_cnt==0); addr holds 0, wr=0.
- Run length, counted in cycles from the start edge to the first cycle done=1:
  - 2*LEN+1 with the feature off.
  - 2*(2*LEN+1) with the feature on.
- Memory read semantics: read-before-write. No phase reads and writes the same address in one cycle.
- Reset mid-run: returns to IDLE immediately. The memory's own synchronous reset is independent and is not driven by this block.

Optional Feature:
- Macro: MEM_BIST_INV_PASS_EN.
- Defined: after D0, run a second write/read/drain pass with the inverted pattern pat1, so every data bit is exercised at both 0 and 1. err_cnt accumulates across both passes. fail_addr is the first mismatch in either pass.
- Undefined: W1/R1/D1 are not present; D0 goes straight to DONE.

Test Plan:
1. LEN=16, DW=8, good memory model, feature off: pulse start for 1 cycle -> busy for 33 cycles, then done=1, pass=1, err_cnt=0, fail_addr=0; wr low after cycle 16.
2. Same setup, memory bit 0 stuck-at-1 at address 4 -> R0 reads 0x05 vs expected 0x04 -> err_cnt=1, fail_addr=4, pass=0. With the feature on, the W1 pattern 0xFB already has bit0=1, so err_cnt stays 1 and done rises after 66 cycles.
3. Feature on, q forced to 0xFF -> 16 mismatches in R0 and 15 in R1 (address 0 matches 0xFF) -> err_cnt=31, fail_addr=0, pass=0.
4. Assert start again at cycle 5 of a run -> no effect; run length unchanged at 33.
5. Assert rst asynchronously at cycle 10 (between edges) -> all outputs read 0 before the next edge. After release, start runs a full clean test with pass=1.
6. After a failing run (scenario 2), repair the memory and pulse start in DONE -> err_cnt/fail_addr clear at the start edge, done drops, the final result is pass=1.
